// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared types and constants for the PS/2 keyboard receiver.
//   - frame_state_t : receive-frame FSM states (IDLE, DATA, PARITY, STOP)
//   - SC_*          : scan-code prefixes and the extended arrow-key codes
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx
//   Receives one 11-bit PS/2 frame (start, 8 data LSB first, odd parity, stop)
//   from the raw pins. Pins are synchronised into the clk domain; the frame FSM
//   advances only on a detected falling edge of the synchronised PS/2 clock.
//   A partial frame with no clock fall for TIMEOUT_CYCLES cycles is aborted.
// Ports
//   clk, resetn  : system clock, asynchronous active-low reset
//   ps2_clk      : raw PS/2 clock pin (async)
//   ps2_dat      : raw PS/2 data pin (async)
//   rx_byte      : received data byte, valid while byte_ok is high
//   byte_ok      : 1-cycle pulse, frame received with good parity and stop
//   err_parity   : 1-cycle pulse, odd-parity check failed
//   err_frame    : 1-cycle pulse, stop bit was 0 or the frame timed out
//   state        : current frame FSM state (debug / checker visibility)
// Handshake: the three pulses are mutually exclusive and are not back-pressured;
//   the consumer must take rx_byte in the same cycle byte_ok is high.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int TMR_W          = 14
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ps2_clk,
  input  logic         ps2_dat,
  output logic [7:0]   rx_byte,
  output logic         byte_ok,
  output logic         err_parity,
  output logic         err_frame,
  output frame_state_t state
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   prev_sync_clk;
  logic                   sync_clk;
  logic                   sync_dat;
  logic                   fall;

  logic [7:0]       shreg;
  logic [2:0]       bit_cnt;
  logic             par;
  logic [TMR_W-1:0] timer;

  assign sync_clk = clk_sync[SYNC_STAGES-1];
  assign sync_dat = dat_sync[SYNC_STAGES-1];
  assign fall     = prev_sync_clk & ~sync_clk;
  assign rx_byte  = shreg;

  // Synchronisers reset to 1 (idle-high bus) so reset release never looks like a fall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync      <= '1;
      dat_sync      <= '1;
      prev_sync_clk <= 1'b1;
    end else begin
      clk_sync      <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync      <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      prev_sync_clk <= sync_clk;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      par        <= 1'b0;
      timer      <= '0;
      byte_ok    <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      byte_ok    <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      if (fall) begin
        // A fall always restarts the timeout, even in the cycle it would expire.
        timer <= '0;
        case (state)
          IDLE: begin
            // A high data line on a fall is treated as a glitch, not an error.
            if (!sync_dat) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {sync_dat, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= sync_dat;
            state <= STOP;
          end
          STOP: begin
            // A bad stop bit outranks a parity failure.
            if (!sync_dat)            err_frame  <= 1'b1;
            else if (^{shreg, par})   byte_ok    <= 1'b1;
            else                      err_parity <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        timer <= '0;
      end else if (timer == TMR_LAST) begin
        timer     <= '0;
        state     <= IDLE;
        err_frame <= 1'b1;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
//   PS/2 keyboard receiver: frame reception plus scan-code prefix decode
//   (E0 = extended, F0 = break) and held-direction levels for the four
//   extended arrow keys.
// Ports
//   clk, resetn  : system clock, asynchronous active-low reset
//   PS2_CLK      : raw PS/2 clock pin (input only, never driven)
//   PS2_DAT      : raw PS/2 data pin
//   code         : last decoded scan code with prefixes stripped
//   code_valid   : 1-cycle pulse, code/code_ext/code_brk just updated
//   code_ext     : code was preceded by E0
//   code_brk     : code was preceded by F0 (key release)
//   err_parity   : 1-cycle pulse, parity error
//   err_frame    : 1-cycle pulse, stop-bit error or timeout abort
//   dir_left/right/up/down : levels, extended arrow key currently held
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int TMR_W          = 14
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       code_ext,
  output logic       code_brk,
  output logic       err_parity,
  output logic       err_frame,
  output logic       dir_left,
  output logic       dir_right,
  output logic       dir_up,
  output logic       dir_down
);

  logic [7:0]   rx_byte;
  logic         byte_ok;
  logic         rx_err_parity;
  logic         rx_err_frame;
  logic         ext_pend;
  logic         brk_pend;
  frame_state_t frame_state;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_frame (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk   (PS2_CLK),
    .ps2_dat   (PS2_DAT),
    .rx_byte   (rx_byte),
    .byte_ok   (byte_ok),
    .err_parity(rx_err_parity),
    .err_frame (rx_err_frame),
    .state     (frame_state)
  );

  // Error pulses are already registered in the frame receiver.
  assign err_parity = rx_err_parity;
  assign err_frame  = rx_err_frame;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      code       <= '0;
      code_valid <= 1'b0;
      code_ext   <= 1'b0;
      code_brk   <= 1'b0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      dir_left   <= 1'b0;
      dir_right  <= 1'b0;
      dir_up     <= 1'b0;
      dir_down   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      if (rx_err_parity || rx_err_frame) begin
        // A damaged frame may have been part of a prefixed sequence; drop it.
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (byte_ok) begin
        case (rx_byte)
          SC_EXT: ext_pend <= 1'b1;
          SC_BRK: brk_pend <= 1'b1;
          default: begin
            code       <= rx_byte;
            code_ext   <= ext_pend;
            code_brk   <= brk_pend;
            code_valid <= 1'b1;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            // Only extended codes move the direction levels; make sets, break clears.
            if (ext_pend) begin
              case (rx_byte)
                SC_LEFT:  dir_left  <= ~brk_pend;
                SC_RIGHT: dir_right <= ~brk_pend;
                SC_UP:    dir_up    <= ~brk_pend;
                SC_DOWN:  dir_down  <= ~brk_pend;
                default:  ;
              endcase
            end
          end
        endcase
      end
    end
  end

  // The frame state is kept visible for hierarchical checkers; nothing here consumes it.
  logic frame_state_unused;
  assign frame_state_unused = ^frame_state;

endmodule
